z_result_stage: RTL and testbench
=================================

# z_result_stage

Holding stage downstream of the ALU datapath. It captures each completed ALU result (rotate, shift, logic, add/sub, MUL/DIV) into the Z register pair and drives it onto the 32-bit internal bus on request. It tracks which halves are still unread and applies backpressure to the ALU until they are consumed. With the flags option compiled in, it also produces zero and negative condition flags for the conditional-branch logic.

## Interface
- `WIDTH`, default 32: bus width. Z holds 2*WIDTH bits.
- `clock`  in  1: sole clock, rising edge.
- `clear`  in  1: synchronous, active-high reset.
- `alu_valid`  in  1: a result is offered this cycle.
- `alu_ready`  out  1: the stage accepts the result this cycle.
- `alu_wide`  in  1: 1 means a 64-bit result (MUL/DIV); 0 means only the low WIDTH bits are meaningful.
- `alu_result`  in  2*WIDTH: result word.
- `ZLowout`  in  1: drive the low half onto the bus.
- `ZHighout`  in  1: drive the high half onto the bus.
- `z_bus_out`  out  WIDTH: bus data.
- `z_bus_drive`  out  1: z_bus_out is valid and this stage owns the bus.
- `rd_err`  out  1: one-cycle pulse on an illegal read.
- `z_zero`  out  1: condition flag, zero.
- `z_neg`  out  1: condition flag, negative.

## Operation
- State machine states:
  - EMPTY: nothing held.
  - LOW_PEND: narrow result, low half unread.
  - BOTH_PEND: wide result, both halves unread.
  - HIGH_PEND: wide result, low half already read.
  - LOW_ONLY: wide result, high half already read.
- `alu_ready` is 1 in EMPTY. It is also 1 in any state where the current cycle's read consumes the last pending half (same-cycle release and refill).
- Accept occurs when `alu_valid` and `alu_ready` are both 1.
  - Z_reg <= `alu_result`.
  - Next state is BOTH_PEND if `alu_wide`, else LOW_PEND.
  - For a narrow result, Z_reg high half <= 0.
- A `ZLowout` read clears the low-pending mark:
  - LOW_PEND → EMPTY.
  - BOTH_PEND → HIGH_PEND.
  - LOW_ONLY → EMPTY.
- A `ZHighout` read clears the high-pending mark:
  - BOTH_PEND → LOW_ONLY.
  - HIGH_PEND → EMPTY.
- Re-reading a half that is already consumed, while the other half is still pending, is legal. It drives the held value and causes no state change.
- `ZHighout` in LOW_PEND drives 0, pulses `rd_err`, and causes no state change.
- Any read in EMPTY drives 0 and pulses `rd_err`.
- If `ZLowout` and `ZHighout` are asserted together:
  - Low wins.
  - `rd_err` pulses.
  - Only the low half is marked read.
- A `clear` asserted mid-operation discards the held result. The stage goes to EMPTY regardless of other inputs that cycle.
- Flags are computed at accept from `alu_result` and held with Z until the next accept. Width rule:
  - Narrow result: `z_zero` = low WIDTH bits all 0; `z_neg` = bit WIDTH-1.
  - Wide result: `z_zero` = all 2*WIDTH bits 0; `z_neg` = bit 2*WIDTH-1.
- `alu_result` is never modified in width or sign; it is stored verbatim apart from zeroing the high half on narrow results.

## Timing
- Reset values:
  - State is EMPTY and Z_reg is 0.
  - `alu_ready` = 1.
  - `z_bus_out` = 0 and `z_bus_drive` = 0.
  - `rd_err` = 0, `z_zero` = 0, `z_neg` = 0.
- Capture latency is 1 cycle. A result accepted at edge N is readable in cycle N+1.
- Bus read is combinational from Z_reg and the out strobes, with zero latency. `z_bus_drive` = `ZLowout` | `ZHighout`.
- `rd_err` is registered and asserts the cycle after the offending read, for exactly one cycle.
- `alu_ready` is combinational from state and the read strobes. No combinational path runs from `alu_valid` to `alu_ready`.
- Last-half read and a new accept in the same cycle:
  - The bus shows the old value that cycle.
  - The new value is readable the next cycle.

## Configuration
- `Z_FLAGS_EN` defined: flag registers and logic are present as described above.
- `Z_FLAGS_EN` undefined:
  - `z_zero` and `z_neg` are tied to 0.
  - No flag flops are built.
  - All other behaviour is identical.

## Structure
- The shared package holds:
  - The state enum typedef (EMPTY, LOW_PEND, BOTH_PEND, HIGH_PEND, LOW_ONLY).
  - The default WIDTH constant.
- One sub-module: `z_flag_gen`. It computes combinational zero/negative from the result and `alu_wide`, and is instantiated only under `Z_FLAGS_EN`.

## Test plan
- Reset, then narrow result:
  - Stimulus: accept 0x0000_0000_8000_0001 with `alu_wide`=0, then assert `ZLowout`.
  - Response: bus shows 0x8000_0001. `z_neg`=1, `z_zero`=0. State returns to EMPTY and `alu_ready`=1.
- Wide result:
  - Stimulus: accept 0x1234_5678_9ABC_DEF0 with `alu_wide`=1, then `ZHighout`, then `ZLowout`.
  - Response: bus shows 0x1234_5678 then 0x9ABC_DEF0. `alu_ready` is low until the second read cycle.
- Backpressure:
  - Stimulus: hold `alu_valid` with a pending result and no reads for 5 cycles.
  - Response: `alu_ready`=0 throughout and Z_reg is unchanged. On the final read, the new result is accepted that same cycle.
- Illegal reads:
  - `ZLowout` in EMPTY → bus 0, `rd_err` pulses one cycle later.
  - `ZLowout` and `ZHighout` together on a wide result → bus shows the low half, `rd_err` pulses, state goes to HIGH_PEND.
- Zero flag:
  - Wide result 0 → `z_zero`=1.
  - Narrow result with low half 0 and nonzero high input bits → `z_zero`=1 and high half reads as 0 (this read also pulses `rd_err`).
- Reset mid-hold:
  - Stimulus: assert `clear` in BOTH_PEND together with `ZLowout` and `alu_valid`.
  - Response: next cycle the state is EMPTY, Z is 0, and nothing is accepted.

Source files
------------

// File: rtl/z_result_stage_pkg.sv
// Shared types and constants for the Z result holding stage.
package z_result_stage_pkg;

  localparam int unsigned Z_WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    EMPTY     = 3'd0,
    LOW_PEND  = 3'd1,
    BOTH_PEND = 3'd2,
    HIGH_PEND = 3'd3,
    LOW_ONLY  = 3'd4
  } z_state_e;

endpackage

// File: rtl/z_result_stage_if.sv
// ALU handshake, bus read strobes and condition flags of the Z result stage.
interface z_result_stage_if
  import z_result_stage_pkg::*;
#(
  parameter int unsigned WIDTH = Z_WIDTH_DEFAULT
);
  logic                 alu_valid;
  logic                 alu_ready;
  logic                 alu_wide;
  logic [2*WIDTH-1:0]   alu_result;
  logic                 ZLowout;
  logic                 ZHighout;
  logic [WIDTH-1:0]     z_bus_out;
  logic                 z_bus_drive;
  logic                 rd_err;
  logic                 z_zero;
  logic                 z_neg;

  modport master (
    output alu_valid, alu_wide, alu_result, ZLowout, ZHighout,
    input  alu_ready, z_bus_out, z_bus_drive, rd_err, z_zero, z_neg
  );

  modport slave (
    input  alu_valid, alu_wide, alu_result, ZLowout, ZHighout,
    output alu_ready, z_bus_out, z_bus_drive, rd_err, z_zero, z_neg
  );
endinterface

// File: rtl/z_result_stage_flag_gen.sv
// Combinational zero/negative flags of an ALU result; only built when Z_FLAGS_EN is defined.
module z_flag_gen
  import z_result_stage_pkg::*;
#(
  parameter int unsigned WIDTH = Z_WIDTH_DEFAULT
) (
  input  logic [2*WIDTH-1:0] result_i,
  input  logic               wide_i,
  output logic               zero_o,
  output logic               neg_o
);

  // Narrow results only look at the low half; the high input bits are don't-care.
  always_comb begin
    if (wide_i) begin
      zero_o = ~|result_i;
      neg_o  = result_i[2*WIDTH-1];
    end else begin
      zero_o = ~|result_i[WIDTH-1:0];
      neg_o  = result_i[WIDTH-1];
    end
  end

endmodule

// File: rtl/z_result_stage.sv
// Z register pair holding ALU results until both halves are read off the bus.
// Optional macro Z_FLAGS_EN adds registered zero/negative condition flags.
module z_result_stage
  import z_result_stage_pkg::*;
#(
  parameter int unsigned WIDTH = Z_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             clear,
  z_result_stage_if.slave  zif
);

  z_state_e             state_q, state_d, rd_state_s;
  logic [2*WIDTH-1:0]   z_q, z_d;
  logic                 rd_err_q, rd_err_d;
  logic [WIDTH-1:0]     bus_s;
  logic                 ready_s, accept_s;

  // Read decode: bus data, illegal-read detection and state after this cycle's read.
  always_comb begin
    rd_state_s = state_q;
    rd_err_d   = 1'b0;
    bus_s      = {WIDTH{1'b0}};
    if (zif.ZLowout) begin
      if (state_q == EMPTY) begin
        rd_err_d = 1'b1;
      end else begin
        rd_err_d = zif.ZHighout;
        bus_s    = z_q[WIDTH-1:0];
      end
      case (state_q)
        LOW_PEND, LOW_ONLY: rd_state_s = EMPTY;
        BOTH_PEND:          rd_state_s = HIGH_PEND;
        default:            rd_state_s = state_q;
      endcase
    end else if (zif.ZHighout) begin
      case (state_q)
        BOTH_PEND: begin
          bus_s      = z_q[2*WIDTH-1:WIDTH];
          rd_state_s = LOW_ONLY;
        end
        HIGH_PEND: begin
          bus_s      = z_q[2*WIDTH-1:WIDTH];
          rd_state_s = EMPTY;
        end
        LOW_ONLY: bus_s = z_q[2*WIDTH-1:WIDTH];
        default:  rd_err_d = 1'b1;
      endcase
    end else begin
      rd_state_s = state_q;
    end
  end

  // Ready depends only on state and read strobes, never on alu_valid.
  assign ready_s  = (rd_state_s == EMPTY);
  assign accept_s = zif.alu_valid & ready_s;

  // Next state and Z contents; a narrow result zeroes the high half.
  always_comb begin
    state_d = rd_state_s;
    z_d     = z_q;
    if (accept_s) begin
      if (zif.alu_wide) begin
        state_d = BOTH_PEND;
        z_d     = zif.alu_result;
      end else begin
        state_d = LOW_PEND;
        z_d     = {{WIDTH{1'b0}}, zif.alu_result[WIDTH-1:0]};
      end
    end else begin
      state_d = rd_state_s;
    end
  end

  // State, Z pair and read-error pulse registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= EMPTY;
      z_q      <= {(2*WIDTH){1'b0}};
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      z_q      <= z_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign zif.alu_ready   = ready_s;
  assign zif.z_bus_out   = bus_s;
  assign zif.z_bus_drive = zif.ZLowout | zif.ZHighout;
  assign zif.rd_err      = rd_err_q;

`ifdef Z_FLAGS_EN
  logic zero_s, neg_s, zero_q, neg_q;

  z_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .result_i (zif.alu_result),
    .wide_i   (zif.alu_wide),
    .zero_o   (zero_s),
    .neg_o    (neg_s)
  );

  // Flags travel with Z: captured on accept, held until the next one.
  always_ff @(posedge clock) begin
    if (clear) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (accept_s) begin
      zero_q <= zero_s;
      neg_q  <= neg_s;
    end else begin
      zero_q <= zero_q;
      neg_q  <= neg_q;
    end
  end

  assign zif.z_zero = zero_q;
  assign zif.z_neg  = neg_q;
`else
  assign zif.z_zero = 1'b0;
  assign zif.z_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_z_result_stage.sv
// Directed self-checking bench for z_result_stage (flag expectations follow Z_FLAGS_EN).
module tb_z_result_stage;
  import z_result_stage_pkg::*;

`ifdef Z_FLAGS_EN
  localparam logic FLG = 1'b1;
`else
  localparam logic FLG = 1'b0;
`endif

  logic clock = 1'b0;
  logic clear = 1'b1;
  int checks = 0;
  int failures = 0;

  z_result_stage_if #(.WIDTH(32)) zif ();

  z_result_stage #(.WIDTH(32)) dut (
    .clock (clock),
    .clear (clear),
    .zif   (zif.slave)
  );

  always #5 clock = ~clock;

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    zif.alu_valid = 1'b0; zif.alu_wide = 1'b0; zif.alu_result = 64'h0;
    zif.ZLowout = 1'b0; zif.ZHighout = 1'b0;
  endtask

  task automatic accept(input logic [63:0] res, input logic wide);
    zif.alu_valid = 1'b1; zif.alu_wide = wide; zif.alu_result = res;
    cycle();
    zif.alu_valid = 1'b0; zif.alu_result = 64'h0;
  endtask

  task automatic test_reset();
    idle(); clear = 1'b1;
    cycle(); cycle();
    clear = 1'b0;
    #1;
    checks++; if (zif.alu_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", zif.alu_ready); end
    checks++; if (zif.z_bus_out !== 32'h0 || zif.z_bus_drive !== 1'b0) begin failures++; $display("FAIL reset_bus got=%h/%b exp=0/0", zif.z_bus_out, zif.z_bus_drive); end
    checks++; if ({zif.rd_err, zif.z_zero, zif.z_neg} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {zif.rd_err, zif.z_zero, zif.z_neg}); end
  endtask

  task automatic test_narrow();
    accept(64'h0000_0000_8000_0001, 1'b0);
    checks++; if (zif.alu_ready !== 1'b0) begin failures++; $display("FAIL narrow_busy got=%b exp=0", zif.alu_ready); end
    checks++; if (zif.z_neg !== FLG || zif.z_zero !== 1'b0) begin failures++; $display("FAIL narrow_flags got=%b%b exp=%b0", zif.z_neg, zif.z_zero, FLG); end
    zif.ZLowout = 1'b1; #1;
    checks++; if (zif.z_bus_out !== 32'h8000_0001 || zif.z_bus_drive !== 1'b1) begin failures++; $display("FAIL narrow_read got=%h/%b exp=80000001/1", zif.z_bus_out, zif.z_bus_drive); end
    checks++; if (zif.alu_ready !== 1'b1) begin failures++; $display("FAIL narrow_release got=%b exp=1", zif.alu_ready); end
    cycle(); zif.ZLowout = 1'b0; #1;
    checks++; if (zif.alu_ready !== 1'b1 || zif.rd_err !== 1'b0) begin failures++; $display("FAIL narrow_empty got=%b/%b exp=1/0", zif.alu_ready, zif.rd_err); end
  endtask

  task automatic test_wide();
    accept(64'h1234_5678_9ABC_DEF0, 1'b1);
    checks++; if (zif.z_neg !== 1'b0 || zif.z_zero !== 1'b0) begin failures++; $display("FAIL wide_flags got=%b%b exp=00", zif.z_neg, zif.z_zero); end
    zif.ZHighout = 1'b1; #1;
    checks++; if (zif.z_bus_out !== 32'h1234_5678 || zif.alu_ready !== 1'b0) begin failures++; $display("FAIL wide_high got=%h/%b exp=12345678/0", zif.z_bus_out, zif.alu_ready); end
    cycle(); zif.ZHighout = 1'b0; zif.ZLowout = 1'b1; #1;
    checks++; if (zif.z_bus_out !== 32'h9ABC_DEF0 || zif.alu_ready !== 1'b1) begin failures++; $display("FAIL wide_low got=%h/%b exp=9abcdef0/1", zif.z_bus_out, zif.alu_ready); end
    cycle(); zif.ZLowout = 1'b0;
  endtask

  task automatic test_back_to_back();
    int busy_bad;
    busy_bad = 0;
    accept(64'h0000_0000_1111_2222, 1'b0);
    zif.alu_valid = 1'b1; zif.alu_wide = 1'b1; zif.alu_result = 64'h5555_6666_7777_8888;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (zif.alu_ready !== 1'b0) busy_bad++;
      cycle();
    end
    checks++; if (busy_bad !== 0) begin failures++; $display("FAIL bp_ready_high got=%0d exp=0", busy_bad); end
    zif.ZLowout = 1'b1; #1;
    checks++; if (zif.z_bus_out !== 32'h1111_2222 || zif.alu_ready !== 1'b1) begin failures++; $display("FAIL bp_old_value got=%h/%b exp=11112222/1", zif.z_bus_out, zif.alu_ready); end
    cycle();
    zif.alu_valid = 1'b0; zif.ZLowout = 1'b0; zif.ZHighout = 1'b1; #1;
    checks++; if (zif.z_bus_out !== 32'h5555_6666) begin failures++; $display("FAIL bp_new_high got=%h exp=55556666", zif.z_bus_out); end
    cycle(); zif.ZHighout = 1'b0; zif.ZLowout = 1'b1; #1;
    checks++; if (zif.z_bus_out !== 32'h7777_8888) begin failures++; $display("FAIL bp_new_low got=%h exp=77778888", zif.z_bus_out); end
    cycle(); zif.ZLowout = 1'b0;
  endtask

  task automatic test_illegal();
    zif.ZLowout = 1'b1; #1;
    checks++; if (zif.z_bus_out !== 32'h0 || zif.z_bus_drive !== 1'b1) begin failures++; $display("FAIL empty_read got=%h/%b exp=0/1", zif.z_bus_out, zif.z_bus_drive); end
    cycle(); zif.ZLowout = 1'b0; #1;
    checks++; if (zif.rd_err !== 1'b1) begin failures++; $display("FAIL empty_err got=%b exp=1", zif.rd_err); end
    cycle();
    checks++; if (zif.rd_err !== 1'b0) begin failures++; $display("FAIL empty_err_pulse got=%b exp=0", zif.rd_err); end
    accept(64'hCAFE_0000_0000_BEEF, 1'b1);
    zif.ZLowout = 1'b1; zif.ZHighout = 1'b1; #1;
    checks++; if (zif.z_bus_out !== 32'h0000_BEEF) begin failures++; $display("FAIL both_read got=%h exp=0000beef", zif.z_bus_out); end
    cycle(); zif.ZLowout = 1'b0; zif.ZHighout = 1'b0; #1;
    checks++; if (zif.rd_err !== 1'b1 || zif.alu_ready !== 1'b0) begin failures++; $display("FAIL both_err got=%b/%b exp=1/0", zif.rd_err, zif.alu_ready); end
    zif.ZHighout = 1'b1; #1;
    checks++; if (zif.z_bus_out !== 32'hCAFE_0000 || zif.alu_ready !== 1'b1) begin failures++; $display("FAIL both_high_pend got=%h/%b exp=cafe0000/1", zif.z_bus_out, zif.alu_ready); end
    cycle(); zif.ZHighout = 1'b0;
  endtask

  task automatic test_zero();
    accept(64'h0, 1'b1);
    checks++; if (zif.z_zero !== FLG || zif.z_neg !== 1'b0) begin failures++; $display("FAIL wide_zero got=%b%b exp=%b0", zif.z_zero, zif.z_neg, FLG); end
    zif.ZLowout = 1'b1; cycle(); zif.ZLowout = 1'b0; zif.ZHighout = 1'b1; cycle(); zif.ZHighout = 1'b0;
    accept(64'hFFFF_0000_0000_0000, 1'b0);
    checks++; if (zif.z_zero !== FLG || zif.z_neg !== 1'b0) begin failures++; $display("FAIL narrow_zero got=%b%b exp=%b0", zif.z_zero, zif.z_neg, FLG); end
    zif.ZHighout = 1'b1; #1;
    checks++; if (zif.z_bus_out !== 32'h0) begin failures++; $display("FAIL narrow_high_read got=%h exp=0", zif.z_bus_out); end
    cycle(); zif.ZHighout = 1'b0; #1;
    checks++; if (zif.rd_err !== 1'b1 || zif.alu_ready !== 1'b0) begin failures++; $display("FAIL narrow_high_err got=%b/%b exp=1/0", zif.rd_err, zif.alu_ready); end
    zif.ZLowout = 1'b1; #1;
    checks++; if (zif.z_bus_out !== 32'h0 || zif.alu_ready !== 1'b1) begin failures++; $display("FAIL narrow_zero_low got=%h/%b exp=0/1", zif.z_bus_out, zif.alu_ready); end
    cycle(); zif.ZLowout = 1'b0;
  endtask

  task automatic test_clear_mid();
    accept(64'h0123_4567_89AB_CDEF, 1'b1);
    clear = 1'b1; zif.ZLowout = 1'b1;
    zif.alu_valid = 1'b1; zif.alu_wide = 1'b1; zif.alu_result = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle();
    clear = 1'b0; idle(); #1;
    checks++; if (zif.alu_ready !== 1'b1 || zif.rd_err !== 1'b0) begin failures++; $display("FAIL clr_state got=%b/%b exp=1/0", zif.alu_ready, zif.rd_err); end
    checks++; if (zif.z_zero !== 1'b0 || zif.z_neg !== 1'b0) begin failures++; $display("FAIL clr_flags got=%b%b exp=00", zif.z_zero, zif.z_neg); end
    zif.ZHighout = 1'b1; #1;
    checks++; if (zif.z_bus_out !== 32'h0) begin failures++; $display("FAIL clr_bus got=%h exp=0", zif.z_bus_out); end
    cycle(); zif.ZHighout = 1'b0; #1;
    checks++; if (zif.rd_err !== 1'b1) begin failures++; $display("FAIL clr_nothing_held got=%b exp=1", zif.rd_err); end
    cycle();
  endtask

  initial begin
    idle();
    test_reset();
    test_narrow();
    test_wide();
    test_back_to_back();
    test_illegal();
    test_zero();
    test_clear_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
